// File: rtl/window_scan_ctrl.sv
// Raster-scan sequencer for the median-filter image memory: reads every 3x3 window,
// hands it to the median unit, and writes the result back to the window centre.
module window_scan_ctrl #(
    parameter int WIDTH  = 430,
    parameter int LENGTH = 554,
    parameter int W_BITS = 9,
    parameter int L_BITS = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mem_ready,
    input  logic              mem_ok,
    output logic [1:0]        mem_state,
    output logic              mem_rw,
    output logic [W_BITS-1:0] mem_w,
    output logic [L_BITS-1:0] mem_l,
    output logic [7:0]        mem_wdata,
    output logic              win_valid,
    input  logic              win_ready,
    input  logic              med_valid,
    input  logic [7:0]        med_data,
    output logic              busy,
    output logic              done
);

    // state      | meaning
    // IDLE       | no pass since reset
    // WAIT_LOAD  | memory in load mode, waiting for mem_ready
    // READ       | window read strobe at (mem_w, mem_l)
    // RDWAIT     | memory window outputs settling
    // PRESENT    | win_valid held until median unit takes it
    // WAIT_MED   | waiting for med_valid, result captured into mem_wdata
    // WRITE      | write strobe to the window centre
    // WAIT_OK    | waiting for memory write acknowledge
    // ADVANCE    | step to next window or finish
    // DONE       | pass complete, done held until next start
    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_WAIT_LOAD = 4'd1,
        S_READ      = 4'd2,
        S_RDWAIT    = 4'd3,
        S_PRESENT   = 4'd4,
        S_WAIT_MED  = 4'd5,
        S_WRITE     = 4'd6,
        S_WAIT_OK   = 4'd7,
        S_ADVANCE   = 4'd8,
        S_DONE      = 4'd9
    } state_t;

    localparam logic [W_BITS-1:0] W_LAST = W_BITS'(WIDTH - 3);
    localparam logic [L_BITS-1:0] L_LAST = L_BITS'(LENGTH - 3);

    state_t state, state_nxt;
    logic   l_more, w_more;

    assign l_more = (mem_l < L_LAST);
    assign w_more = (mem_w < W_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mem_state = 2'd1;
        mem_rw    = 1'b0;
        win_valid = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                mem_state = 2'd0;
                busy      = 1'b0;
                if (start) state_nxt = S_WAIT_LOAD;
            end
            S_WAIT_LOAD: begin
                mem_state = 2'd0;
                if (mem_ready) state_nxt = S_READ;
            end
            S_READ:   state_nxt = S_RDWAIT;
            S_RDWAIT: state_nxt = S_PRESENT;
            S_PRESENT: begin
                win_valid = 1'b1;
                if (win_ready) state_nxt = S_WAIT_MED;
            end
            S_WAIT_MED: begin
                if (med_valid) state_nxt = S_WRITE;
            end
            S_WRITE: begin
                mem_rw    = 1'b1;
                state_nxt = S_WAIT_OK;
            end
            S_WAIT_OK: begin
                if (mem_ok) state_nxt = S_ADVANCE;
            end
            S_ADVANCE: begin
                state_nxt = (l_more || w_more) ? S_READ : S_DONE;
            end
            S_DONE: begin
                busy = 1'b0;
                done = 1'b1;
                if (start) state_nxt = S_WAIT_LOAD;
            end
            default: begin
                mem_state = 2'd0;
                busy      = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Coordinates only move in ADVANCE, so they stay stable through the whole handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_w     <= '0;
            mem_l     <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        mem_w <= '0;
                        mem_l <= '0;
                    end
                end
                S_WAIT_MED: begin
                    if (med_valid) mem_wdata <= med_data;
                end
                S_ADVANCE: begin
                    if (l_more) begin
                        mem_l <= mem_l + L_BITS'(1);
                    end else if (w_more) begin
                        mem_l <= '0;
                        mem_w <= mem_w + W_BITS'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_window_scan_ctrl.sv
// Self-checking bench for window_scan_ctrl: randomized memory/median responders
// checked against an ordered list of expected windows.
module tb_window_scan_ctrl;
    localparam int WIDTH  = 5;
    localparam int LENGTH = 6;
    localparam int W_BITS = 9;
    localparam int L_BITS = 10;
    localparam int N_WIN  = (WIDTH - 2) * (LENGTH - 2);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              mem_ready = 1'b0;
    logic              mem_ok = 1'b0;
    logic              win_ready = 1'b0;
    logic              med_valid = 1'b0;
    logic [7:0]        med_data = 8'd0;
    logic [1:0]        mem_state;
    logic              mem_rw;
    logic [W_BITS-1:0] mem_w;
    logic [L_BITS-1:0] mem_l;
    logic [7:0]        mem_wdata;
    logic              win_valid;
    logic              busy;
    logic              done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    window_scan_ctrl #(
        .WIDTH(WIDTH), .LENGTH(LENGTH), .W_BITS(W_BITS), .L_BITS(L_BITS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mem_ready(mem_ready), .mem_ok(mem_ok),
        .mem_state(mem_state), .mem_rw(mem_rw), .mem_w(mem_w), .mem_l(mem_l),
        .mem_wdata(mem_wdata), .win_valid(win_valid), .win_ready(win_ready),
        .med_valid(med_valid), .med_data(med_data), .busy(busy), .done(done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // expected window order, built directly from the scan rule
    int exp_w[$];
    int exp_l[$];
    int mode = 0;
    bit start_req = 0, abort_arm = 0, abort_hit = 0;
    bit med_pend = 0, wait_write = 0, ok_pend = 0;
    int med_cnt = 0, ok_cnt = 0, cur_w = 0, cur_l = 0;
    int writes = 0, hs_count = 0, cycle = 0, last_hs = 0, bp_cnt = 0;
    logic [7:0] exp_data = 8'd0;

    task automatic build_model();
        exp_w.delete();
        exp_l.delete();
        for (int w = 0; w + 2 < WIDTH; w++)
            for (int l = 0; l + 2 < LENGTH; l++) begin
                exp_w.push_back(w);
                exp_l.push_back(l);
            end
        writes   = 0;
        hs_count = 0;
        bp_cnt   = 0;
    endtask

    // environment: samples outputs and drives inputs on the falling edge
    always @(negedge clk) begin
        cycle++;
        if (!rst_n) begin
            med_pend = 0; wait_write = 0; ok_pend = 0;
            win_ready = 0; med_valid = 0; mem_ok = 0; start = 0;
        end else begin
            if (start_req) begin
                start = 1'b1;
                start_req = 0;
            end else begin
                start = (mode == 1 && busy) ? 1'($urandom_range(0, 1)) : 1'b0;
            end

            med_valid = 1'b0;
            if (med_pend) begin
                if (med_cnt == 0) begin
                    med_valid = 1'b1;
                    med_data  = (cur_w == 1 && cur_l == 3) ? 8'hA5 : 8'($urandom);
                    exp_data  = med_data;
                    med_pend  = 0;
                    wait_write = 1;
                end else begin
                    med_cnt--;
                end
            end else if (mode == 1 && !wait_write) begin
                med_valid = 1'($urandom_range(0, 1));
                med_data  = 8'($urandom);
            end

            mem_ok = 1'b0;
            if (ok_pend) begin
                check("waitok_w", mem_w, cur_w);
                check("waitok_l", mem_l, cur_l);
                if (ok_cnt == 0) begin
                    mem_ok = 1'b1;
                    ok_pend = 0;
                end else begin
                    ok_cnt--;
                end
            end
            if (mem_rw) begin
                check("wr_expected", wait_write, 1);
                check("wr_data", mem_wdata, exp_data);
                check("wr_w", mem_w, cur_w);
                check("wr_l", mem_l, cur_l);
                wait_write = 0;
                writes++;
                ok_pend = 1;
                ok_cnt  = (mode == 0) ? 0 : (cur_w == 1 && cur_l == 3) ? 3 : $urandom_range(0, 2);
            end

            win_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (win_valid) begin
                if (exp_w.size() == 0) begin
                    check("win_extra", 1, 0);
                    win_ready = 1'b0;
                end else begin
                    check("win_w", mem_w, exp_w[0]);
                    check("win_l", mem_l, exp_l[0]);
                    check("win_rw", mem_rw, 0);
                    if (mode == 0) begin
                        win_ready = 1'b1;
                    end else if (exp_w[0] == 1 && exp_l[0] == 2) begin
                        win_ready = (bp_cnt >= 5);
                        bp_cnt++;
                    end else begin
                        win_ready = ($urandom_range(0, 2) != 0);
                    end
                    if (win_ready) begin
                        cur_w = exp_w.pop_front();
                        cur_l = exp_l.pop_front();
                        if (mode == 0 && hs_count > 0) check("win_spacing", cycle - last_hs, 7);
                        last_hs = cycle;
                        hs_count++;
                        med_pend = 1;
                        med_cnt  = (mode == 0) ? 0 : (cur_w == 1 && cur_l == 3) ? 4 : $urandom_range(0, 3);
                        if (abort_arm && cur_w == 2 && cur_l == 1) begin
                            med_cnt   = 1000;
                            abort_hit = 1;
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic begin_pass(input int m);
        mode = m;
        build_model();
        mem_ready = 1'b0;
        start_req = 1;
        for (int i = 0; i < 10 && !busy; i++) tick();
        check("start_busy", busy, 1);
        check("start_done", done, 0);
        check("start_w", mem_w, 0);
        check("start_l", mem_l, 0);
        for (int i = 0; i < 3; i++) begin
            check("load_state", mem_state, 0);
            tick();
        end
        mem_ready = 1'b1;
        tick();
        check("filter_state", mem_state, 1);
        if (m == 1) mem_ready = 1'b0;
    endtask

    task automatic finish_pass();
        for (int i = 0; i < 5000 && !done; i++) tick();
        check("pass_done", done, 1);
        check("pass_writes", writes, N_WIN);
        check("pass_left", exp_w.size(), 0);
        check("pass_busy", busy, 0);
        check("pass_w", mem_w, WIDTH - 3);
        check("pass_l", mem_l, LENGTH - 3);
        repeat (4) tick();
        check("done_sticky", done, 1);
        check("done_state", mem_state, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_state"}, mem_state, 0);
        check({tag, "_rw"}, mem_rw, 0);
        check({tag, "_w"}, mem_w, 0);
        check({tag, "_l"}, mem_l, 0);
        check({tag, "_wdata"}, mem_wdata, 0);
        check({tag, "_valid"}, win_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    initial begin
        repeat (2) tick();
        check_all_zero("rst");
        rst_n = 1'b1;
        repeat (2) tick();

        begin_pass(0);
        finish_pass();

        begin_pass(1);
        finish_pass();

        abort_arm = 1;
        begin_pass(0);
        for (int i = 0; i < 2000 && !abort_hit; i++) tick();
        check("abort_reached", abort_hit, 1);
        tick();
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        abort_arm = 0;
        mem_ready = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        begin_pass(1);
        finish_pass();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/window_scan_ctrl.md
Name: window_scan_ctrl

Overview:
- Initiator/sequencer for the median-filter image memory.
- Drives memory mode, window coordinates and read/write strobe over a raster scan of every 3x3 window.
- Hands each window to the median unit through a valid/ready handshake, then writes the median result back to the window centre.
- Sits between the image memory and the median sorter; owns all memory addressing during filtering.

Parameters:
- WIDTH, 430, image rows (w axis).
- LENGTH, 554, image columns (l axis).
- W_BITS, 9, width of mem_w.
- L_BITS, 10, width of mem_l.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse: begin a filter pass
- mem_ready  in  1  memory load complete (memory input_done)
- mem_ok  in  1  memory write acknowledge (memory ok)
- mem_state  out  2  memory mode: 0 = load, 1 = filter
- mem_rw  out  1  1 = write centre pixel, 0 = read window
- mem_w  out  W_BITS  window top row
- mem_l  out  L_BITS  window left column
- mem_wdata  out  8  pixel written to centre (memory in)
- win_valid  out  1  memory window outputs valid for median unit
- win_ready  in  1  median unit accepts window
- med_valid  in  1  median result valid
- med_data  in  8  median result
- busy  out  1  pass in progress
- done  out  1  pass complete; sticky until next start

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0: mem_state, mem_rw, mem_w, mem_l, mem_wdata, win_valid, busy, done.
- Reset mid-pass aborts immediately. Memory contents are not restored.
- States: IDLE, WAIT_LOAD, READ, RDWAIT, PRESENT, WAIT_MED, WRITE, WAIT_OK, ADVANCE, DONE.
- IDLE/DONE:
  - start=1 -> WAIT_LOAD; busy=1; done=0; mem_w=0; mem_l=0.
  - start is ignored in every other state.
- WAIT_LOAD: mem_state=0. Stay until mem_ready=1, then -> READ. mem_state=1 from READ onward through DONE.
- READ (1 cycle): mem_rw=0 with current mem_w/mem_l. The memory registers the window at the end of this cycle -> RDWAIT.
- RDWAIT (1 cycle): window outputs settle -> PRESENT.
- PRESENT: win_valid=1, held with coordinates stable until win_ready=1. Handshake completes on that edge -> WAIT_MED. win_valid is 0 in every other state.
- WAIT_MED: wait for med_valid=1. Capture med_data into mem_wdata on that edge -> WRITE. med_valid in any other state is ignored.
- WRITE (1 cycle): mem_rw=1. mem_wdata is written to (mem_w+1, mem_l+1) -> WAIT_OK.
- WAIT_OK: mem_rw=0. Stay until mem_ok=1 -> ADVANCE.
- ADVANCE (1 cycle):
  - If mem_l < LENGTH-3: mem_l++ -> READ.
  - Else if mem_w < WIDTH-3: mem_l=0, mem_w++ -> READ.
  - Else -> DONE; busy=0; done=1.
- Scan order: l inner loop, w outer loop. Windows = (WIDTH-2)*(LENGTH-2). Defaults: 428*552 = 236256. No window ever addresses beyond WIDTH-1 / LENGTH-1.
- Write-back is in place. Later windows read already-filtered neighbours; this is intended and matches the golden model.
- Minimum cost per window: 7 cycles (win_ready and med_valid each immediate).
- Counter comparisons use full W_BITS/L_BITS. No wrap: ADVANCE never increments past the last index.
- mem_ready dropping after WAIT_LOAD is ignored.

Test Plan:
- WIDTH=5, LENGTH=6, reset then start with mem_ready=1 after 3 cycles, win_ready and med_valid always 1:
  - mem_state=0 until mem_ready, then 1.
  - Exactly 12 win_valid handshakes with (w,l) = (0,0),(0,1),(0,2),(0,3),(1,0)...(2,3).
  - done=1 after the 12th mem_ok; window spacing 7 cycles.
- Backpressure: hold win_ready=0 for 5 cycles on window (1,2) -> win_valid stays 1, mem_w=1, mem_l=2 stable, no mem_rw=1 pulse; progress resumes after win_ready=1.
- med_data=8'hA5 arriving 4 cycles after handshake -> exactly one mem_rw=1 cycle with mem_wdata=8'hA5 at the same coordinates; no write before med_valid.
- mem_ok delayed 3 cycles -> FSM holds in WAIT_OK, coordinates unchanged, no second write.
- Assert rst_n=0 at window (2,1) mid-WAIT_MED:
  - All outputs 0 immediately.
  - A later start restarts from (0,0); start pulses during busy are ignored.
- Default parameters, full pass with an ideal memory/median model: 236256 writes, final window (427,551), done sticky until the next start.
